// File: rtl/golden_nonce_buffer.sv
// golden_nonce_buffer
//
// Captures every winning (nonce, hash) pair reported by the hash/target
// comparator into a small FIFO. The host drains it through a valid/ready port.
// Hits and dropped hits are counted for the host status registers.
//
// Ports:
//   clk        system clock, rising edge
//   rst_n      asynchronous active-low reset
//   clear      synchronous clear: empties FIFO and zeroes both counters
//   cmp_valid  comparator evaluated a hash this cycle
//   cmp_hit    evaluated hash met the target (qualified by cmp_valid)
//   cmp_nonce  nonce that produced cmp_hash
//   cmp_hash   hash under evaluation
//   out_valid  FIFO head holds an entry
//   out_ready  host consumes the head entry this cycle
//   out_nonce  head nonce, 0 when out_valid is low
//   out_hash   head hash, 0 when out_valid is low
//   level      current occupancy
//   full       level == DEPTH
//   hit_cnt    saturating count of all hits, dropped ones included
//   drop_cnt   saturating count of hits lost because the FIFO was full

module golden_nonce_buffer #(
  parameter int DEPTH   = 4,
  parameter int NONCE_W = 32,
  parameter int HASH_W  = 256,
  parameter int CNT_W   = 16
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       clear,
  input  logic                       cmp_valid,
  input  logic                       cmp_hit,
  input  logic [NONCE_W-1:0]         cmp_nonce,
  input  logic [HASH_W-1:0]          cmp_hash,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [NONCE_W-1:0]         out_nonce,
  output logic [HASH_W-1:0]          out_hash,
  output logic [$clog2(DEPTH):0]     level,
  output logic                       full,
  output logic [CNT_W-1:0]           hit_cnt,
  output logic [CNT_W-1:0]           drop_cnt
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = PTR_W + 1;

  logic [NONCE_W-1:0] nonce_mem [DEPTH];
  logic [HASH_W-1:0]  hash_mem  [DEPTH];

  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;

  logic hit;
  logic pop;
  logic push;
  logic drop;

  // Occupancy is the only source of empty/full; pointers just wrap naturally
  // because DEPTH is a power of two.
  assign out_valid = (level != '0);
  assign full      = (level == LVL_W'(DEPTH));

  // A pop frees a slot in the same cycle, so a full FIFO that is being drained
  // still accepts the incoming hit.
  assign hit  = cmp_valid & cmp_hit;
  assign pop  = out_valid & out_ready;
  assign push = hit & (~full | pop);
  assign drop = hit & full & ~pop;

  // Head is read straight from registered storage (first-word fall-through),
  // gated so the host never sees stale RAM contents.
  assign out_nonce = out_valid ? nonce_mem[rd_ptr] : '0;
  assign out_hash  = out_valid ? hash_mem[rd_ptr]  : '0;

  // Storage RAM carries no reset; a clear suppresses the write so a hit in the
  // clear cycle leaves no trace.
  always_ff @(posedge clk) begin
    if (push && !clear) begin
      nonce_mem[wr_ptr] <= cmp_nonce;
      hash_mem[wr_ptr]  <= cmp_hash;
    end
  end

  // Pointers and occupancy. clear overrides any push/pop in the same cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      if (push && !pop) begin
        level <= level + LVL_W'(1);
      end else if (pop && !push) begin
        level <= level - LVL_W'(1);
      end
    end
  end

  // Statistics counters saturate at all-ones rather than wrapping, so the host
  // can tell "very many" from "a few".
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hit_cnt  <= '0;
      drop_cnt <= '0;
    end else if (clear) begin
      hit_cnt  <= '0;
      drop_cnt <= '0;
    end else begin
      if (hit && (hit_cnt != '1)) begin
        hit_cnt <= hit_cnt + CNT_W'(1);
      end
      if (drop && (drop_cnt != '1)) begin
        drop_cnt <= drop_cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_golden_nonce_buffer.sv
// tb_golden_nonce_buffer
//
// Directed self-checking bench for golden_nonce_buffer (DEPTH=4, NONCE_W=32,
// HASH_W=256, CNT_W=16). Inputs are driven 1 time unit after each rising
// edge and outputs are sampled at that same point, well away from the edge.

module tb_golden_nonce_buffer;

  logic         clk;
  logic         rst_n;
  logic         clear;
  logic         cmp_valid;
  logic         cmp_hit;
  logic [31:0]  cmp_nonce;
  logic [255:0] cmp_hash;
  logic         out_valid;
  logic         out_ready;
  logic [31:0]  out_nonce;
  logic [255:0] out_hash;
  logic [2:0]   level;
  logic         full;
  logic [15:0]  hit_cnt;
  logic [15:0]  drop_cnt;

  int checkCount = 0;
  int failCount  = 0;

  golden_nonce_buffer #(
    .DEPTH  (4),
    .NONCE_W(32),
    .HASH_W (256),
    .CNT_W  (16)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .clear    (clear),
    .cmp_valid(cmp_valid),
    .cmp_hit  (cmp_hit),
    .cmp_nonce(cmp_nonce),
    .cmp_hash (cmp_hash),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_nonce(out_nonce),
    .out_hash (out_hash),
    .level    (level),
    .full     (full),
    .hit_cnt  (hit_cnt),
    .drop_cnt (drop_cnt)
  );

  // 10-unit clock, rising edges at 5, 15, 25, ...
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Hash paired with each nonce: the nonce replicated eight times.
  function automatic logic [255:0] hashOf(input logic [31:0] n);
    return {8{n}};
  endfunction

  // Advance one clock and settle 1 unit past the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Drive one cycle of inputs and advance past the next edge.
  task automatic applyStimulus(input logic v, input logic h, input logic [31:0] n,
                               input logic rdy, input logic clr);
    cmp_valid = v;
    cmp_hit   = h;
    cmp_nonce = n;
    cmp_hash  = hashOf(n);
    out_ready = rdy;
    clear     = clr;
    step();
    cmp_valid = 1'b0;
    cmp_hit   = 1'b0;
    out_ready = 1'b0;
    clear     = 1'b0;
  endtask

  task automatic checkOutput(input string tag, input logic [255:0] observed,
                             input logic [255:0] expected);
    checkCount++;
    assert (observed === expected)
    else begin
      failCount++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  initial begin
    rst_n     = 1'b0;
    clear     = 1'b0;
    cmp_valid = 1'b0;
    cmp_hit   = 1'b0;
    cmp_nonce = '0;
    cmp_hash  = '0;
    out_ready = 1'b0;

    // ---------------- reset state ----------------
    #12;
    checkOutput("rst_out_valid", 256'(out_valid), 256'd0);
    checkOutput("rst_full",      256'(full),      256'd0);
    checkOutput("rst_level",     256'(level),     256'd0);
    checkOutput("rst_hit_cnt",   256'(hit_cnt),   256'd0);
    checkOutput("rst_drop_cnt",  256'(drop_cnt),  256'd0);
    checkOutput("rst_out_nonce", 256'(out_nonce), 256'd0);
    rst_n = 1'b1;
    step();

    // ---------------- 1: single hit then pop ----------------
    $display("[TB] test 1: single hit");
    applyStimulus(1'b1, 1'b1, 32'h0000_1234, 1'b0, 1'b0);
    checkOutput("t1_out_valid", 256'(out_valid), 256'd1);
    checkOutput("t1_out_nonce", 256'(out_nonce), 256'h1234);
    checkOutput("t1_out_hash",  out_hash, {8{32'h0000_1234}});
    checkOutput("t1_level",     256'(level),     256'd1);
    checkOutput("t1_hit_cnt",   256'(hit_cnt),   256'd1);
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
    checkOutput("t1_pop_level",     256'(level),     256'd0);
    checkOutput("t1_pop_out_valid", 256'(out_valid), 256'd0);
    checkOutput("t1_pop_out_nonce", 256'(out_nonce), 256'd0);
    checkOutput("t1_pop_out_hash",  out_hash,        256'd0);

    applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
    checkOutput("clr_hit_cnt", 256'(hit_cnt), 256'd0);

    // ---------------- 2: overflow by two ----------------
    $display("[TB] test 2: overflow");
    for (int i = 0; i < 6; i++) begin
      applyStimulus(1'b1, 1'b1, 32'(i), 1'b0, 1'b0);
    end
    checkOutput("t2_level",    256'(level),    256'd4);
    checkOutput("t2_full",     256'(full),     256'd1);
    checkOutput("t2_hit_cnt",  256'(hit_cnt),  256'd6);
    checkOutput("t2_drop_cnt", 256'(drop_cnt), 256'd2);
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
    checkOutput("t2_head_stable", 256'(out_nonce), 256'd0);
    checkOutput("t2_head_valid",  256'(out_valid), 256'd1);
    for (int i = 0; i < 4; i++) begin
      checkOutput($sformatf("t2_drain_nonce%0d", i), 256'(out_nonce), 256'(i));
      checkOutput($sformatf("t2_drain_hash%0d", i), out_hash, {8{32'(i)}});
      applyStimulus(1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
    end
    checkOutput("t2_drained_level", 256'(level), 256'd0);
    checkOutput("t2_drained_full",  256'(full),  256'd0);

    // ---------------- 3: full + hit + pop ----------------
    $display("[TB] test 3: full with simultaneous pop");
    for (int i = 10; i < 14; i++) begin
      applyStimulus(1'b1, 1'b1, 32'(i), 1'b0, 1'b0);
    end
    checkOutput("t3_full_before", 256'(full), 256'd1);
    applyStimulus(1'b1, 1'b1, 32'd99, 1'b1, 1'b0);
    checkOutput("t3_level",    256'(level),    256'd4);
    checkOutput("t3_drop_cnt", 256'(drop_cnt), 256'd2);
    checkOutput("t3_hit_cnt",  256'(hit_cnt),  256'd11);
    checkOutput("t3_head",     256'(out_nonce), 256'd11);
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
    checkOutput("t3_drain1", 256'(out_nonce), 256'd12);
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
    checkOutput("t3_drain2", 256'(out_nonce), 256'd13);
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
    checkOutput("t3_last",   256'(out_nonce), 256'd99);
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
    checkOutput("t3_empty",  256'(out_valid), 256'd0);

    // ---------------- 4: non-hits ignored ----------------
    $display("[TB] test 4: non-hits");
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
    checkOutput("t4_clr_drop_cnt", 256'(drop_cnt), 256'd0);
    for (int i = 0; i < 100; i++) begin
      applyStimulus(1'b1, 1'b0, 32'(i + 500), 1'b0, 1'b0);
    end
    checkOutput("t4_miss_level",   256'(level),   256'd0);
    checkOutput("t4_miss_hit_cnt", 256'(hit_cnt), 256'd0);
    for (int i = 0; i < 10; i++) begin
      applyStimulus(1'b0, 1'b1, 32'(i + 700), 1'b0, 1'b0);
    end
    checkOutput("t4_invalid_level",     256'(level),     256'd0);
    checkOutput("t4_invalid_hit_cnt",   256'(hit_cnt),   256'd0);
    checkOutput("t4_invalid_out_valid", 256'(out_valid), 256'd0);

    // ---------------- 5: clear beats hit ----------------
    $display("[TB] test 5: clear with hit");
    for (int i = 20; i < 23; i++) begin
      applyStimulus(1'b1, 1'b1, 32'(i), 1'b0, 1'b0);
    end
    checkOutput("t5_level_before", 256'(level),   256'd3);
    checkOutput("t5_hits_before",  256'(hit_cnt), 256'd3);
    applyStimulus(1'b1, 1'b1, 32'd30, 1'b0, 1'b1);
    checkOutput("t5_level",     256'(level),     256'd0);
    checkOutput("t5_hit_cnt",   256'(hit_cnt),   256'd0);
    checkOutput("t5_out_valid", 256'(out_valid), 256'd0);
    // After a clear the write pointer restarts at slot 0.
    applyStimulus(1'b1, 1'b1, 32'd40, 1'b0, 1'b0);
    checkOutput("t5_post_clear_head", 256'(out_nonce), 256'd40);
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 1'b1);

    // ---------------- 6: async reset, saturation ----------------
    $display("[TB] test 6: async reset and saturation");
    applyStimulus(1'b1, 1'b1, 32'd50, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b1, 32'd51, 1'b0, 1'b0);
    checkOutput("t6_level_before", 256'(level), 256'd2);
    #3;
    rst_n = 1'b0;
    #1;
    checkOutput("t6_async_out_valid", 256'(out_valid), 256'd0);
    checkOutput("t6_async_level",     256'(level),     256'd0);
    checkOutput("t6_async_hit_cnt",   256'(hit_cnt),   256'd0);
    checkOutput("t6_async_out_nonce", 256'(out_nonce), 256'd0);
    #2;
    rst_n = 1'b1;
    step();
    force dut.hit_cnt = 16'hFFFF;
    #1;
    release dut.hit_cnt;
    #1;
    checkOutput("t6_forced", 256'(hit_cnt), 256'hFFFF);
    #1;
    applyStimulus(1'b1, 1'b1, 32'd60, 1'b0, 1'b0);
    checkOutput("t6_saturated", 256'(hit_cnt), 256'hFFFF);
    checkOutput("t6_sat_level", 256'(level),   256'd1);

    $display("%0d/%0d checks passed", checkCount - failCount, checkCount);
    $finish;
  end

endmodule
